// File: rtl/fwd_hazard_unit_if.sv
// Bundle between the 5-stage pipeline and the forwarding/hazard unit.
// The pipeline side drives the master modport and the unit takes the slave modport.
interface fwd_hazard_unit_if #(
  parameter int NPORTS = 2,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic [NPORTS*REG_W-1:0]  id_src_i;
  logic [NPORTS-1:0]        id_use_i;
  logic [REG_W-1:0]         ex_rw_i;
  logic                     ex_wen_i;
  logic                     ex_memread_i;
  logic [REG_W-1:0]         mem_rw_i;
  logic                     mem_wen_i;
  logic [DATA_W-1:0]        mem_data_i;
  logic [DATA_W-1:0]        wb_data_i;
  logic [NPORTS*DATA_W-1:0] ex_rdat_i;
  logic                     ex_en_i;
  logic                     flush_i;
  logic [NPORTS*DATA_W-1:0] ex_opnd_o;
  logic [NPORTS*2-1:0]      fwd_sel_o;
  logic                     stall_o;
  logic [CNT_W-1:0]         stall_cnt_o;

  modport master (
    output id_src_i, id_use_i, ex_rw_i, ex_wen_i, ex_memread_i, mem_rw_i, mem_wen_i,
           mem_data_i, wb_data_i, ex_rdat_i, ex_en_i, flush_i,
    input  ex_opnd_o, fwd_sel_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  id_src_i, id_use_i, ex_rw_i, ex_wen_i, ex_memread_i, mem_rw_i, mem_wen_i,
           mem_data_i, wb_data_i, ex_rdat_i, ex_en_i, flush_i,
    output ex_opnd_o, fwd_sel_o, stall_o, stall_cnt_o
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding unit: the selects are resolved in ID and registered at ID/EX, so EX only sees a small mux.
// It also generates multi-cycle load-use stalls and keeps a saturating count of stall cycles.
module fwd_hazard_unit #(
  parameter int NPORTS   = 2,
  parameter int REG_W    = 5,
  parameter int DATA_W   = 32,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  fwd_hazard_unit_if.slave bus
);
  localparam int CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_STALL = 1'b1;

  logic [NPORTS-1:0]              hit_ex, hit_mem;
  logic [NPORTS-1:0][1:0]         sel_d, sel_q;
  logic [NPORTS-1:0][DATA_W-1:0]  opnd;
  logic [0:0]                     state_d, state_q;
  logic [CW-1:0]                  cnt_d, cnt_q;
  logic [CNT_W-1:0]               stall_cnt_q;
  logic                           luse, stall;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [REG_W-1:0] src;
    logic             rd;
    assign src = bus.id_src_i[p*REG_W +: REG_W];
    // r0 is hardwired zero, so it never forwards or stalls.
    assign rd  = bus.id_use_i[p] && (src != '0);
    assign hit_ex[p]  = rd && bus.ex_wen_i  && (bus.ex_rw_i  == src);
    assign hit_mem[p] = rd && bus.mem_wen_i && (bus.mem_rw_i == src);

    always_comb begin
      sel_d[p] = 2'b00;
      if (hit_ex[p])       sel_d[p] = 2'b01;
      else if (hit_mem[p]) sel_d[p] = 2'b10;
    end

    always_comb begin
      opnd[p] = bus.ex_rdat_i[p*DATA_W +: DATA_W];
      case (sel_q[p])
        2'b01:   opnd[p] = bus.mem_data_i;
        2'b10:   opnd[p] = bus.wb_data_i;
        default: opnd[p] = bus.ex_rdat_i[p*DATA_W +: DATA_W];
      endcase
    end
  end

  assign luse  = bus.ex_memread_i && (|hit_ex);
  assign stall = (((state_q == S_IDLE) && luse) || (state_q == S_STALL)) && !bus.flush_i;

  // The IDLE cycle that detects the hazard is the first stall cycle, so STALL covers LOAD_LAT-1 more.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (luse && (LOAD_LAT > 1)) begin
          state_d = S_STALL;
          cnt_d   = CW'(LOAD_LAT - 1);
        end
        default: if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (bus.flush_i || stall) sel_q <= '0;
      else if (bus.ex_en_i)     sel_q <= sel_d;
      if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.ex_opnd_o   = opnd;
  assign bus.fwd_sel_o   = sel_q;
  assign bus.stall_o     = stall;
  assign bus.stall_cnt_o = stall_cnt_q;
endmodule
